// File: rtl/cpu_hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } hz_state_e;

  localparam int unsigned FlushCyclesDefault = 2;
  localparam int unsigned MemTimeoutDefault  = 64;
  localparam int unsigned PerfCntW           = 32;

endpackage

// File: rtl/cpu_hazard_detect.sv
// Load-use detection: EX load whose destination feeds a source read by the ID instruction.
module cpu_hazard_detect
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ra_id,
  input  logic [REG_ADDR_W-1:0] rb_id,
  input  logic                  ra_used_id,
  input  logic                  rb_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  load_ex,
  output logic                  load_use
);

  // r0 is compared like any other register; the forwarding unit uses the same rule.
  assign load_use = load_ex & ((ra_used_id & (ra_id == rd_ex)) |
                               (rb_used_id & (rb_id == rd_ex)));

endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Stall/flush/bubble sequencer for the 5-stage core: load-use, branch flush, dmem freeze.
// Define HAZARD_PERF_CNT_EN to add the stall/flush/timeout performance counters.
module cpu_hazard_ctrl
  import cpu_hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault,
  parameter int unsigned MEM_TIMEOUT  = MemTimeoutDefault
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ra_id,
  input  logic [REG_ADDR_W-1:0] rb_id,
  input  logic                  ra_used_id,
  input  logic                  rb_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  load_ex,
  input  logic                  branch_taken_ex,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  bubble_ex,
  output logic                  flush_if,
  output logic                  flush_id,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PerfCntW-1:0]   perf_stall_cycles,
  output logic [PerfCntW-1:0]   perf_flush_events,
  output logic [PerfCntW-1:0]   perf_timeouts,
`endif
  output logic                  mem_timeout
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(FLUSH_CYCLES - 1);

  hz_state_e          state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [FlushW-1:0]  flush_cnt_q, flush_cnt_d;
  logic               ret_flush_q, ret_flush_d;

  logic load_use, mem_miss, release_wait;
  logic freeze, flush_on, lu_stall, tmo_pulse;

  cpu_hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .ra_id     (ra_id),
    .rb_id     (rb_id),
    .ra_used_id(ra_used_id),
    .rb_used_id(rb_used_id),
    .rd_ex     (rd_ex),
    .load_ex   (load_ex),
    .load_use  (load_use)
  );

  assign mem_miss = dmem_req & ~dmem_ready;
  // Leaving MEM_WAIT: either the access completed or the wait budget ran out.
  assign release_wait = dmem_ready | (wait_cnt_q == WaitLast);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
      ret_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ret_flush_q <= ret_flush_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ret_flush_d = ret_flush_q;
    case (state_q)
      RUN: begin
        if (mem_miss) begin
          state_d     = MEM_WAIT;
          wait_cnt_d  = '0;
          ret_flush_d = 1'b0;
        end else if (branch_taken_ex) begin
          flush_cnt_d = FlushInit;
          if (FLUSH_CYCLES > 1) state_d = FLUSH;
        end
      end
      MEM_WAIT: begin
        if (!release_wait) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d     = ret_flush_q ? FLUSH : RUN;
          ret_flush_d = 1'b0;
          // A branch held in EX restarts the flush window; a resumed flush keeps its count.
          if (branch_taken_ex) begin
            flush_cnt_d = FlushInit;
            if (FLUSH_CYCLES > 1) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (mem_miss) begin
          state_d     = MEM_WAIT;
          wait_cnt_d  = '0;
          ret_flush_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == FlushW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    freeze    = 1'b0;
    flush_on  = 1'b0;
    lu_stall  = 1'b0;
    tmo_pulse = 1'b0;
    if (reset) begin
      case (state_q)
        RUN: begin
          if (mem_miss) freeze = 1'b1;
          else if (branch_taken_ex) flush_on = 1'b1;
          else if (load_use) lu_stall = 1'b1;
        end
        MEM_WAIT: begin
          if (!release_wait) begin
            freeze = 1'b1;
          end else begin
            tmo_pulse = ~dmem_ready;
            if (branch_taken_ex) flush_on = 1'b1;
            else if (load_use) lu_stall = 1'b1;
          end
        end
        FLUSH: begin
          flush_on = 1'b1;
          freeze   = mem_miss;
        end
        default: ;
      endcase
    end
  end

  assign stall_if    = freeze | lu_stall;
  assign stall_id    = freeze | lu_stall;
  assign stall_ex    = freeze;
  assign stall_mem   = freeze;
  assign bubble_ex   = lu_stall;
  assign flush_if    = flush_on;
  assign flush_id    = flush_on;
  assign mem_timeout = tmo_pulse;

`ifdef HAZARD_PERF_CNT_EN
  logic [PerfCntW-1:0] stall_cyc_q, flush_evt_q, tmo_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cyc_q <= '0;
      flush_evt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      if (freeze | lu_stall) stall_cyc_q <= stall_cyc_q + 1'b1;
      if ((state_q == RUN) && !mem_miss && branch_taken_ex) flush_evt_q <= flush_evt_q + 1'b1;
      if (tmo_pulse) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_cyc_q;
  assign perf_flush_events = flush_evt_q;
  assign perf_timeouts     = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: three parameterisations driven in lockstep, checked against
// directed expectations and a cycle-level reference model of the hazard rules.
module tb_cpu_hazard_ctrl;

  localparam int FcP [3] = '{2, 1, 3};
  localparam int MtP [3] = '{4, 64, 6};

  // Output vector order: {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, flush_if, flush_id, mem_timeout}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_FRZ   = 8'hF0;
  localparam logic [7:0] O_LU    = 8'hC8;
  localparam logic [7:0] O_FL    = 8'h06;
  localparam logic [7:0] O_FRZFL = 8'hF6;
  localparam logic [7:0] O_TMO   = 8'h01;

  typedef struct {
    int ra, rb, rd, rau, rbu, ld, br, req, rdy;
    logic [7:0] want;
  } row_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] ra = '0, rb = '0, rd = '0;
  logic       rau = 1'b0, rbu = 1'b0, ld = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  wire  [7:0] obs_w [3];
`ifdef HAZARD_PERF_CNT_EN
  wire  [31:0] perf_st [3];
  wire  [31:0] perf_fl [3];
  wire  [31:0] perf_to [3];
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state per configuration
  bit         m_wait [3];
  int         m_waited [3];
  int         m_fl [3];
  bit         m_res [3];
  logic [7:0] exp_o [3];
  int         p_stall, p_flush, p_tmo;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_hazard_ctrl #(
      .REG_ADDR_W  (5),
      .FLUSH_CYCLES(FcP[g]),
      .MEM_TIMEOUT (MtP[g])
    ) dut (
      .clock          (clock),
      .reset          (reset),
      .ra_id          (ra),
      .rb_id          (rb),
      .ra_used_id     (rau),
      .rb_used_id     (rbu),
      .rd_ex          (rd),
      .load_ex        (ld),
      .branch_taken_ex(br),
      .dmem_req       (req),
      .dmem_ready     (rdy),
      .stall_if       (obs_w[g][7]),
      .stall_id       (obs_w[g][6]),
      .stall_ex       (obs_w[g][5]),
      .stall_mem      (obs_w[g][4]),
      .bubble_ex      (obs_w[g][3]),
      .flush_if       (obs_w[g][2]),
      .flush_id       (obs_w[g][1]),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cycles(perf_st[g]),
      .perf_flush_events(perf_fl[g]),
      .perf_timeouts    (perf_to[g]),
`endif
      .mem_timeout    (obs_w[g][0])
    );
  end

  function automatic logic [7:0] obs(int k);
    case (k)
      0:       return obs_w[0];
      1:       return obs_w[1];
      default: return obs_w[2];
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_wait[k] = 0; m_waited[k] = 0; m_fl[k] = 0; m_res[k] = 0; exp_o[k] = O_NONE;
    end
    p_stall = 0; p_flush = 0; p_tmo = 0;
  endtask

  // One cycle of the hazard rules, expressed as "cycles waited" and "flush cycles left".
  task automatic model_eval();
    bit lu, miss, frz, fl, lus, tmo;
    lu   = ld && ((rau && ra == rd) || (rbu && rb == rd));
    miss = req && !rdy;
    for (int k = 0; k < 3; k++) begin
      frz = 0; fl = 0; lus = 0; tmo = 0;
      if (m_wait[k]) begin
        if (!rdy && m_waited[k] < MtP[k] - 1) begin
          frz = 1;
          m_waited[k]++;
        end else begin
          tmo = !rdy;
          m_wait[k] = 0;
          if (br) begin fl = 1; m_fl[k] = FcP[k] - 1; end
          else if (lu) lus = 1;
          m_res[k] = 0;
        end
      end else if (m_fl[k] > 0) begin
        fl = 1;
        if (miss) begin frz = 1; m_wait[k] = 1; m_waited[k] = 0; m_res[k] = 1; end
        else m_fl[k]--;
      end else begin
        if (miss) begin frz = 1; m_wait[k] = 1; m_waited[k] = 0; m_res[k] = 0; end
        else if (br) begin
          fl = 1; m_fl[k] = FcP[k] - 1;
          if (k == 0) p_flush++;
        end else if (lu) lus = 1;
      end
      exp_o[k] = {frz | lus, frz | lus, frz, frz, lus, fl, fl, tmo};
      if (k == 0) begin
        if (frz | lus) p_stall++;
        if (tmo) p_tmo++;
      end
    end
  endtask

  task automatic cyc(input row_t r);
    @(negedge clock);
    ra  = 5'(r.ra);  rb  = 5'(r.rb);  rd  = 5'(r.rd);
    rau = (r.rau != 0); rbu = (r.rbu != 0); ld = (r.ld != 0);
    br  = (r.br != 0);  req = (r.req != 0); rdy = (r.rdy != 0);
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    ra = 5'd3; rd = 5'd3; rau = 1'b1; ld = 1'b1; br = 1'b1; req = 1'b1; rdy = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== O_NONE) begin
        failures++; $display("FAIL reset_outputs dut%0d: got %b want %b", k, obs(k), O_NONE);
      end
    end
    model_clear();
    {ra, rd, rau, ld, br, req, rdy} = '0;
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_load_use();
    row_t rows [6] = '{
      '{3, 0, 3, 1, 0, 1, 0, 0, 0, O_LU},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{3, 0, 3, 0, 0, 1, 0, 0, 0, O_NONE},
      '{1, 3, 3, 1, 1, 1, 0, 0, 0, O_LU},
      '{0, 0, 0, 1, 0, 1, 0, 0, 0, O_LU},
      '{3, 3, 3, 1, 1, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 6; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL load_use row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL load_use_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_branch();
    row_t rows [9] = '{
      '{0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{3, 0, 3, 1, 0, 1, 1, 0, 0, O_FL},
      '{3, 0, 3, 1, 0, 1, 0, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 1, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 9; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL branch row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL branch_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    row_t rows [6] = '{
      '{0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE},
      '{3, 0, 3, 1, 0, 1, 0, 1, 0, O_FRZ},
      '{3, 0, 3, 1, 0, 1, 0, 1, 0, O_FRZ},
      '{3, 0, 3, 1, 0, 1, 0, 1, 0, O_FRZ},
      '{3, 0, 3, 1, 0, 1, 0, 1, 1, O_LU},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 6; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL mem_wait row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL mem_wait_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    row_t rows [14] = '{
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_TMO},
      '{0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 14; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL timeout row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL timeout_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    row_t rows [8] = '{
      '{3, 0, 3, 1, 0, 1, 1, 1, 0, O_FRZ},
      '{3, 0, 3, 1, 0, 1, 1, 1, 1, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZFL},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_FL},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 8; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL simultaneous row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL simultaneous_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t miss = '{3, 0, 3, 1, 0, 1, 1, 1, 0, O_FRZ};
    row_t rows [5] = '{
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ},
      '{0, 0, 0, 0, 0, 0, 0, 0, 1, O_NONE},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE}};
    for (int i = 0; i < 3; i++) begin
      cyc(miss);
      checks++;
      if (obs(0) !== O_FRZ) begin
        failures++; $display("FAIL reset_mid_pre cyc%0d: got %b want %b", i, obs(0), O_FRZ);
      end
    end
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== O_NONE) begin
        failures++; $display("FAIL reset_mid_async dut%0d: got %b want %b", k, obs(k), O_NONE);
      end
    end
    model_clear();
    @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== O_NONE) begin
        failures++; $display("FAIL reset_mid_held dut%0d: got %b want %b", k, obs(k), O_NONE);
      end
    end
    {ra, rd, rau, ld, br, req, rdy} = '0;
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(rows[i]);
      checks++;
      if (obs(0) !== rows[i].want) begin
        failures++; $display("FAIL reset_mid_after row%0d: got %b want %b", i, obs(0), rows[i].want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL reset_mid_model dut%0d row%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    row_t r;
    for (int i = 0; i < 3000; i++) begin
      r.ra   = int'($urandom_range(0, 3));
      r.rb   = int'($urandom_range(0, 3));
      r.rd   = int'($urandom_range(0, 3));
      r.rau  = int'($urandom_range(0, 1));
      r.rbu  = int'($urandom_range(0, 1));
      r.ld   = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r.br   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r.req  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r.rdy  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r.want = O_NONE;
      cyc(r);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_o[k]) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d: got %b want %b", k, i, obs(k), exp_o[k]);
        end
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    @(posedge clock);
    #1;
    checks++;
    if (perf_st[0] !== 32'(p_stall)) begin
      failures++; $display("FAIL perf_stall: got %0d want %0d", perf_st[0], p_stall);
    end
    checks++;
    if (perf_fl[0] !== 32'(p_flush)) begin
      failures++; $display("FAIL perf_flush: got %0d want %0d", perf_fl[0], p_flush);
    end
    checks++;
    if (perf_to[0] !== 32'(p_tmo)) begin
      failures++; $display("FAIL perf_timeouts: got %0d want %0d", perf_to[0], p_tmo);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_hazard_ctrl.md
Name: cpu_hazard_ctrl

Overview:
Pipeline hazard and stall sequencer for the 5-stage core (IF/ID/EX/MEM(commit)/WB). It is the companion of the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use stalls with bubble insertion;
- branch-taken flushes of IF/ID over a programmable number of cycles;
- whole-pipeline freeze while a data-memory access is outstanding, with a timeout.

It drives the stall/flush/bubble enables of the pipeline registers.

Parameters:
REG_ADDR_W, 5, register index width
FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high per taken branch (>=1)
MEM_TIMEOUT, 64, max cycles in MEM_WAIT before forced release (>=2)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset
ra_id  in  REG_ADDR_W  source A of instruction in ID
rb_id  in  REG_ADDR_W  source B of instruction in ID
ra_used_id  in  1  ID instruction reads ra
rb_used_id  in  1  ID instruction reads rb
rd_ex  in  REG_ADDR_W  destination of instruction in EX
load_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved a taken branch/jump
dmem_req  in  1  MEM stage has a data access this cycle
dmem_ready  in  1  data memory completes the access this cycle
stall_if  out  1  hold PC / IF-ID register
stall_id  out  1  hold ID-EX register
stall_ex  out  1  hold EX-MEM register
stall_mem  out  1  hold MEM-WB register
bubble_ex  out  1  load a NOP into ID-EX
flush_if  out  1  invalidate IF-ID contents
flush_id  out  1  invalidate ID-EX contents
mem_timeout  out  1  one-cycle pulse on forced MEM_WAIT release

Behaviour:
- State register: RUN, MEM_WAIT, FLUSH. Counters: wait_cnt (clog2(MEM_TIMEOUT)), flush_cnt (clog2(FLUSH_CYCLES+1)), ret_flush bit. All reset asynchronously on reset=0 to RUN/0/0/0.
- Outputs are combinational from state and inputs (zero-latency Mealy). While reset=0, every output is 0.
- load_use = load_ex & ((ra_used_id & ra_id==rd_ex) | (rb_used_id & rb_id==rd_ex)). Register 0 gets no special treatment.
- mem_miss = dmem_req & !dmem_ready.
- RUN, evaluated in priority order:
  1) mem_miss: all four stall_* = 1, no flush or bubble. Next state MEM_WAIT, wait_cnt=0, ret_flush=0.
  2) branch_taken_ex: flush_if = flush_id = 1. If FLUSH_CYCLES>1, next state FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise stay in RUN. Any load_use in the same cycle is ignored.
  3) load_use: stall_if = stall_id = 1, bubble_ex = 1. This lasts one cycle because the load then advances to MEM.
- MEM_WAIT:
  - With dmem_ready=0: all stall_* = 1, wait_cnt increments.
  - With dmem_ready=1: freeze drops in this cycle, and the RUN rules 2 and 3 apply to the held EX/ID contents. Next state is FLUSH if ret_flush=1, otherwise RUN.
  - If wait_cnt == MEM_TIMEOUT-1 and dmem_ready=0: mem_timeout=1, freeze drops, and the exit is taken as if ready had arrived.
  - branch_taken_ex and load_use are ignored while frozen.
- FLUSH:
  - flush_if = flush_id = 1 and flush_cnt decrements. When flush_cnt==1, next state is RUN.
  - If mem_miss occurs: freeze instead, flush outputs stay 1, and flush_cnt is held. Next state MEM_WAIT with ret_flush=1.
  - load_use is ignored, since ID is being flushed.
- Precedence: freeze > flush > load-use stall. The bubble is never asserted together with any freeze.
- Reset mid-operation: immediate return to RUN with all outputs 0, regardless of state or counters.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three outputs, each a 32-bit wrapping counter cleared by reset:
  - perf_stall_cycles: +1 per cycle with any stall_* asserted.
  - perf_flush_events: +1 per branch_taken_ex accepted in RUN.
  - perf_timeouts: +1 per mem_timeout pulse.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - the state enum hz_state_e {RUN, MEM_WAIT, FLUSH};
  - localparam defaults for FLUSH_CYCLES and MEM_TIMEOUT;
  - the perf counter width constant.
- One sub-module, cpu_hazard_detect: purely combinational load_use comparison. It sits alongside the forwarding unit and reuses the same ID/EX register fields.
- The FSM and counters stay in cpu_hazard_ctrl.

Test Plan:
- Load-use: load_ex=1, rd_ex=3, ra_id=3, ra_used_id=1 for one cycle -> stall_if=stall_id=bubble_ex=1 that cycle only. Same stimulus with ra_used_id=0 -> all outputs 0.
- Branch: branch_taken_ex pulse with FLUSH_CYCLES=2 -> flush_if/flush_id high 2 consecutive cycles, then RUN. With FLUSH_CYCLES=1 -> 1 cycle, FSM stays in RUN.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> all stall_* = 1 for exactly 3 cycles, 0 on the ready cycle. A concurrent load_use is served on the ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready never asserted -> stalls for cycles 0-2, cycle 3 has mem_timeout=1 and stalls=0, then RUN.
- Simultaneous: mem_miss + branch_taken_ex + load_use in one cycle -> freeze only. On release, flush applies; a second miss during FLUSH resumes the remaining flush cycles afterwards.
- Reset: assert reset=0 during cycle 2 of MEM_WAIT -> outputs 0 immediately (asynchronously). After release, state RUN, no stale stall or timeout.
